// File: rtl/char_plane_pkg.sv
// Shared definitions for the scrolling character plane.
// Holds the sequencer state encoding and the default geometry constants
// used as parameter defaults by scroll_char_plane.
package char_plane_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ALL = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    localparam int         DEF_ROWS      = 15;
    localparam int         DEF_COLS      = 40;
    localparam int         DEF_CHAR_W    = 8;
    localparam int         DEF_ROW_W     = 4;
    localparam int         DEF_COL_W     = 6;
    localparam logic [7:0] DEF_FILL_CHAR = 8'h00;

endpackage

// File: rtl/plane_ram.sv
// Simple dual-port character RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old data.
// No reset; contents are defined by the owner's clear sequence.
// Ports:
//   clock    - rising-edge clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address (sampled each cycle)
//   rd_q     - read data, one cycle after rd_addr
module plane_ram #(
    parameter int DEPTH  = 600,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

endmodule

// File: rtl/scroll_char_plane.sv
// Character plane of ROWS x COLS character IDs for the text renderer.
// Scrolling rotates a top-row pointer in constant time; a sequencer then
// blanks the newly exposed bottom row. A second sequence fills the whole
// plane with FILL_CHAR after reset or on request.
// Ports:
//   clock, reset        - clock and asynchronous active-high reset
//   clear, scroll       - single-cycle request pulses
//   we, wr_row, wr_col, wr_data - user write port (logical row)
//   rd_row, rd_col      - read address (logical row)
//   rd_data             - read data, one cycle latency
//   busy                - a clear sequence is running; user writes dropped
module scroll_char_plane #(
    parameter int                ROWS      = char_plane_pkg::DEF_ROWS,
    parameter int                COLS      = char_plane_pkg::DEF_COLS,
    parameter int                CHAR_W    = char_plane_pkg::DEF_CHAR_W,
    parameter int                ROW_W     = char_plane_pkg::DEF_ROW_W,
    parameter int                COL_W     = char_plane_pkg::DEF_COL_W,
    parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(char_plane_pkg::DEF_FILL_CHAR)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              scroll,
    input  logic              we,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_data,
    output logic              busy
);
    import char_plane_pkg::*;

    localparam int                ADDR_W   = $clog2(ROWS * COLS);
    localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(COLS - 1);

    // Advance a physical row index, wrapping at ROWS.
    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
        return (r == ROW_W'(ROWS - 1)) ? '0 : r + 1'b1;
    endfunction

    // Logical (row, col) to RAM address under top pointer t. Both operands
    // are below ROWS, so one conditional subtract replaces a modulo.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] t,
                                                    input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        logic [ROW_W:0] sum;
        sum = {1'b0, t} + {1'b0, r};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [ROW_W-1:0]  top, top_nxt;
    logic [ROW_W-1:0]  clr_row, clr_row_nxt;
    logic              pend_clr, pend_clr_nxt;
    logic              pend_scr, pend_scr_nxt;
    logic              req_clr, req_scr, seq_last;
    logic              rd_ok, rd_vld, rd_oob;
    logic              user_we, ram_we;
    logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
    logic [CHAR_W-1:0] ram_wr_data, ram_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= CLEAR_ALL;
            cnt      <= '0;
            top      <= '0;
            clr_row  <= '0;
            pend_clr <= 1'b0;
            pend_scr <= 1'b0;
            busy     <= 1'b1;
            rd_vld   <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            top      <= top_nxt;
            clr_row  <= clr_row_nxt;
            pend_clr <= pend_clr_nxt;
            pend_scr <= pend_scr_nxt;
            busy     <= (state_nxt != IDLE);
            rd_vld   <= 1'b1;
            rd_oob   <= !rd_ok;
        end
    end

    // Requests seen while busy, including ones arriving on the final cycle
    // of a sequence. A clear cancels any queued scroll.
    assign req_clr  = pend_clr | clear;
    assign req_scr  = clear ? 1'b0 : (pend_scr | scroll);
    assign seq_last = (state == CLEAR_ALL) ? (cnt == LAST_ALL) : (cnt == LAST_ROW);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        top_nxt      = top;
        clr_row_nxt  = clr_row;
        pend_clr_nxt = pend_clr;
        pend_scr_nxt = pend_scr;
        case (state)
            IDLE: begin
                if (clear) begin
                    top_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = CLEAR_ALL;
                end else if (scroll) begin
                    clr_row_nxt = top;
                    top_nxt     = row_inc(top);
                    cnt_nxt     = '0;
                    state_nxt   = CLEAR_ROW;
                end
            end
            default: begin
                pend_clr_nxt = req_clr;
                pend_scr_nxt = req_scr;
                cnt_nxt      = cnt + 1'b1;
                if (seq_last) begin
                    cnt_nxt = '0;
                    if (req_clr) begin
                        pend_clr_nxt = 1'b0;
                        top_nxt      = '0;
                        state_nxt    = CLEAR_ALL;
                    end else if (req_scr) begin
                        pend_scr_nxt = 1'b0;
                        clr_row_nxt  = top;
                        top_nxt      = row_inc(top);
                        state_nxt    = CLEAR_ROW;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    // Write port: the sequencer owns it whenever a clear is running.
    assign user_we = (state == IDLE) && !busy && we &&
                     (wr_row < ROW_W'(ROWS)) && (wr_col < COL_W'(COLS));

    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = FILL_CHAR;
        if (state == CLEAR_ALL) begin
            ram_we      = 1'b1;
            ram_wr_addr = cnt;
        end else if (state == CLEAR_ROW) begin
            ram_we      = 1'b1;
            ram_wr_addr = ADDR_W'(clr_row) * ADDR_W'(COLS) + cnt;
        end else if (user_we) begin
            ram_we      = 1'b1;
            ram_wr_addr = cell_addr(top, wr_row, wr_col);
            ram_wr_data = wr_data;
        end
    end

    assign rd_ok       = (rd_row < ROW_W'(ROWS)) && (rd_col < COL_W'(COLS));
    assign ram_rd_addr = rd_ok ? cell_addr(top, rd_row, rd_col) : '0;

    plane_ram #(
        .DEPTH  (ROWS * COLS),
        .ADDR_W (ADDR_W),
        .DATA_W (CHAR_W)
    ) u_ram (
        .clock   (clock),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (ram_rd_addr),
        .rd_q    (ram_q)
    );

    // Out-of-range reads return FILL_CHAR; the output reads 0 until the
    // first clock after reset.
    assign rd_data = !rd_vld ? '0 : (rd_oob ? FILL_CHAR : ram_q);

endmodule

// File: tb/tb_scroll_char_plane.sv
// Self-checking bench for scroll_char_plane at default geometry.
// A logical-plane model (rows shift up on scroll) predicts every read;
// predictions are queued when a read is issued and compared one cycle later.
module tb_scroll_char_plane;

    localparam logic [7:0] FILL = 8'h00;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       scroll = 1'b0;
    logic       we = 1'b0;
    logic [3:0] wr_row = '0;
    logic [5:0] wr_col = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] rd_row = '0;
    logic [5:0] rd_col = '0;
    logic [7:0] rd_data;
    logic       busy;

    int checks = 0;
    int passed = 0;

    logic [7:0] lm [15][40];
    logic [7:0] exp_q [$];

    scroll_char_plane dut (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .scroll  (scroll),
        .we      (we),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                lm[r][c] = FILL;
    endtask

    task automatic model_scroll;
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 40; c++)
                lm[r][c] = lm[r+1][c];
        for (int c = 0; c < 40; c++)
            lm[14][c] = FILL;
    endtask

    task automatic model_write(input int r, input int c, input logic [7:0] d);
        if (r < 15 && c < 40) lm[r][c] = d;
    endtask

    task automatic drive_write(input int r, input int c, input logic [7:0] d);
        we = 1'b1; wr_row = 4'(r); wr_col = 6'(c); wr_data = d;
    endtask

    task automatic do_write(input int r, input int c, input logic [7:0] d);
        drive_write(r, c, d);
        tick;
        we = 1'b0;
        model_write(r, c, d);
    endtask

    // Present a read address and queue its predicted result.
    task automatic rd_issue(input int r, input int c);
        rd_row = 4'(r);
        rd_col = 6'(c);
        if (r < 15 && c < 40) exp_q.push_back(lm[r][c]);
        else                  exp_q.push_back(FILL);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] e;
        int n;
        repeat (3) tick;
        checks++;
        if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy);
        else passed++;
        checks++;
        if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        else passed++;
        reset = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 600) $display("FAIL reset_clear_len: got %0d expected 600", n);
        else passed++;
        model_clear;
        rd_issue(0, 0);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL reset_rd_0_0: got %h expected %h", rd_data, e);
        else passed++;
        rd_issue(14, 39);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL reset_rd_14_39: got %h expected %h", rd_data, e);
        else passed++;
    endtask

    task automatic test_write_read;
        logic [7:0] e;
        do_write(3, 5, 8'h41);
        rd_issue(3, 5);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL wr_rd_3_5: got %h expected %h", rd_data, e);
        else passed++;
        rd_issue(15, 0);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL rd_row_oob: got %h expected %h", rd_data, e);
        else passed++;
        rd_issue(3, 40);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL rd_col_oob: got %h expected %h", rd_data, e);
        else passed++;
        // Out-of-range write must be dropped, not aliased.
        do_write(2, 45, 8'hC3);
        rd_issue(3, 5);
        drive_write(3, 5, 8'h55);
        tick;
        we = 1'b0;
        model_write(3, 5, 8'h55);
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL collision_old: got %h expected %h", rd_data, e);
        else passed++;
        rd_issue(3, 5);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL collision_new: got %h expected %h", rd_data, e);
        else passed++;
        for (int c = 0; c < 40; c++) begin
            rd_issue(2, c);
            tick;
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) $display("FAIL oob_write_row2 c=%0d: got %h expected %h", c, rd_data, e);
            else passed++;
        end
    endtask

    task automatic test_scroll;
        logic [7:0] e;
        int n;
        do_write(1, 0, 8'h42);
        do_write(0, 3, 8'h77);
        checks++;
        if (busy !== 1'b0) $display("FAIL scroll_idle_busy: got %b expected 0", busy);
        else passed++;
        scroll = 1'b1;
        tick;
        scroll = 1'b0;
        model_scroll;
        n = 0;
        while (busy && n < 2000) begin
            if (n == 3) drive_write(5, 5, 8'hEE);
            tick;
            we = 1'b0;
            n++;
        end
        checks++;
        if (n !== 40) $display("FAIL scroll_busy_len: got %0d expected 40", n);
        else passed++;
        rd_issue(0, 0);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL scroll_rd_0_0: got %h expected %h", rd_data, e);
        else passed++;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                rd_issue(r, c);
                tick;
                e = exp_q.pop_front();
                checks++;
                if (rd_data !== e) $display("FAIL scroll_scan r=%0d c=%0d: got %h expected %h", r, c, rd_data, e);
                else passed++;
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        int n;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        count_busy(n);
        model_clear;
        checks++;
        if (n !== 600) $display("FAIL wrap_clear_len: got %0d expected 600", n);
        else passed++;
        checks++;
        if (dut.top !== 4'd0) $display("FAIL wrap_top_start: got %0d expected 0", dut.top);
        else passed++;
        do_write(0, 7, 8'h99);
        do_write(3, 3, 8'h13);
        for (int i = 1; i <= 15; i++) begin
            if (i == 1) begin drive_write(0, 10, 8'h5A); model_write(0, 10, 8'h5A); end
            if (i == 2) begin drive_write(5, 1, 8'h33); model_write(5, 1, 8'h33); end
            scroll = 1'b1;
            tick;
            scroll = 1'b0;
            we = 1'b0;
            model_scroll;
            count_busy(n);
            checks++;
            if (n !== 40) $display("FAIL wrap_busy_len i=%0d: got %0d expected 40", i, n);
            else passed++;
            checks++;
            if (dut.top !== 4'(i % 15)) $display("FAIL wrap_top i=%0d: got %0d expected %0d", i, dut.top, i % 15);
            else passed++;
            if (i == 3 || i == 15) begin
                for (int r = 0; r < 15; r++) begin
                    for (int c = 0; c < 40; c++) begin
                        rd_issue(r, c);
                        tick;
                        e = exp_q.pop_front();
                        checks++;
                        if (rd_data !== e) $display("FAIL wrap_scan i=%0d r=%0d c=%0d: got %h expected %h", i, r, c, rd_data, e);
                        else passed++;
                    end
                end
            end
        end
        do_write(14, 39, 8'hAB);
        rd_issue(14, 39);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL wrap_rd_14_39: got %h expected %h", rd_data, e);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        int n;
        do_write(4, 4, 8'h21);
        scroll = 1'b1;
        tick;
        scroll = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            if (n == 2)  scroll = 1'b1;
            if (n == 5)  drive_write(2, 2, 8'hEE);
            if (n == 10) clear = 1'b1;
            tick;
            scroll = 1'b0;
            clear = 1'b0;
            we = 1'b0;
            n++;
        end
        model_clear;
        checks++;
        if (n !== 640) $display("FAIL b2b_busy_len: got %0d expected 640", n);
        else passed++;
        checks++;
        if (dut.top !== 4'd0) $display("FAIL b2b_top: got %0d expected 0", dut.top);
        else passed++;
        tick;
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_no_pending_scroll: got %b expected 0", busy);
        else passed++;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                rd_issue(r, c);
                tick;
                e = exp_q.pop_front();
                checks++;
                if (rd_data !== e) $display("FAIL b2b_scan r=%0d c=%0d: got %h expected %h", r, c, rd_data, e);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] e;
        int n;
        do_write(6, 6, 8'h66);
        scroll = 1'b1;
        tick;
        scroll = 1'b0;
        repeat (10) tick;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) $display("FAIL rstmid_busy: got %b expected 1", busy);
        else passed++;
        checks++;
        if (dut.top !== 4'd0) $display("FAIL rstmid_top: got %0d expected 0", dut.top);
        else passed++;
        checks++;
        if (rd_data !== 8'h00) $display("FAIL rstmid_rd_data: got %h expected 00", rd_data);
        else passed++;
        tick;
        reset = 1'b0;
        count_busy(n);
        model_clear;
        checks++;
        if (n !== 600) $display("FAIL rstmid_clear_len: got %0d expected 600", n);
        else passed++;
        rd_issue(5, 6);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL rstmid_rd_5_6: got %h expected %h", rd_data, e);
        else passed++;
        do_write(7, 8, 8'h78);
        rd_issue(7, 8);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) $display("FAIL rstmid_wr_rd: got %h expected %h", rd_data, e);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_scroll;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
